// File: rtl/axis_packet_gen_if.sv
// AXI4-Stream bundle between the packet generator and its sink.
// The master drives data/valid/last and the slave returns ready.
interface axis_packet_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_packet_gen.sv
// AXIS test packet generator: incrementing data, tlast framing, optional gap.
// AXIS_PACKET_GEN_STALL_CNT_EN adds a saturating backpressure counter.
module axis_packet_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  num_pkts,
  output logic                  busy,
  output logic                  done,
`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
  output logic [31:0]           stall_cnt,
`endif
  axis_packet_gen_if.master     m_axis
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_ok;
  logic                  accept;

  assign start_ok = start && (pkt_len != '0) && (num_pkts != '0);
  assign accept   = valid_q && m_axis.tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      num_q   <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      num_q   <= num_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    beat_d  = beat_q;
    num_d   = num_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          data_d  = seed;
          len_d   = pkt_len;
          num_d   = num_pkts;
          beat_d  = '0;
          pkt_d   = '0;
          gap_d   = '0;
          valid_d = 1'b1;
          last_d  = (pkt_len == LEN_WIDTH'(1));
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          data_d = data_q + DATA_WIDTH'(1);
          if (last_q) begin
            beat_d = '0;
            if (pkt_q == num_q - CNT_WIDTH'(1)) begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
              state_d = FINISH;
            end else begin
              pkt_d  = pkt_q + CNT_WIDTH'(1);
              last_d = (len_q == LEN_WIDTH'(1));
              if (GAP_CYCLES != 0) begin
                valid_d = 1'b0;
                gap_d   = '0;
                state_d = GAP;
              end
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
            // next beat is the last one when beat_q + 1 == len - 1
            last_d = (beat_q + LEN_WIDTH'(2) == len_q);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          valid_d = 1'b1;
          state_d = SEND;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start_ok) begin
      stall_q <= '0;
    end else if (valid_q && !m_axis.tready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_axis_packet_gen.sv
// Bench for axis_packet_gen: a back-to-back instance and a GAP_CYCLES=2
// instance share stimulus and are checked against an arithmetic model.
module tb_axis_packet_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        tready = 1'b0;
  logic [31:0] seed = '0;
  logic [15:0] pkt_len = '0;
  logic [7:0]  num_pkts = '0;
  logic        busy0, done0, busy1, done1;

  int checks = 0;
  int errors = 0;

  axis_packet_gen_if #(.DATA_WIDTH(32)) ax0 ();
  axis_packet_gen_if #(.DATA_WIDTH(32)) ax1 ();
  assign ax0.tready = tready;
  assign ax1.tready = tready;

`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
  logic [31:0] sc[2];
`endif

  axis_packet_gen #(.GAP_CYCLES(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .seed(seed), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .busy(busy0), .done(done0),
`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
    .stall_cnt(sc[0]),
`endif
    .m_axis(ax0)
  );

  axis_packet_gen #(.GAP_CYCLES(2)) dut_gap (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .seed(seed), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .busy(busy1), .done(done1),
`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
    .stall_cnt(sc[1]),
`endif
    .m_axis(ax1)
  );

  always #5 aclk = ~aclk;

  logic [31:0] td[2];
  logic        tv[2], tl[2], bz[2], dn[2];
  assign td[0] = ax0.tdata;  assign td[1] = ax1.tdata;
  assign tv[0] = ax0.tvalid; assign tv[1] = ax1.tvalid;
  assign tl[0] = ax0.tlast;  assign tl[1] = ax1.tlast;
  assign bz[0] = busy0;      assign bz[1] = busy1;
  assign dn[0] = done0;      assign dn[1] = done1;

  // results of one observed run, per instance
  logic [31:0] bd[2][64];
  logic        bl[2][64];
  int          gaps[2][8];
  int          nb[2], ng[2], stalls[2], hold_err[2], busy_err[2];
  int          last_acc[2], done_at[2];
  bit          dseen[2];

  function automatic logic [31:0] mdata(input logic [31:0] s, input int i);
    return s + 32'(i);
  endfunction

  function automatic logic mlast(input int len, input int i);
    return (i % len) == (len - 1);
  endfunction

  task automatic do_start(input logic [31:0] s, input int len, input int num);
    seed = s; pkt_len = 16'(len); num_pkts = 8'(num); start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  // mode 0: ready always, 1: pattern 1,0,0, 2: random
  task automatic collect(input int mode, input int budget, input int restart_at);
    bit          in_gap[2], stl[2], r;
    int          gcnt[2];
    logic [31:0] pd[2];
    logic        pl[2];
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; ng[k] = 0; stalls[k] = 0; hold_err[k] = 0; busy_err[k] = 0;
      last_acc[k] = -1; done_at[k] = -1; dseen[k] = 0;
      in_gap[k] = 0; stl[k] = 0; gcnt[k] = 0; pd[k] = '0; pl[k] = 0;
    end
    for (int c = 0; c < budget && !(dseen[0] && dseen[1]); c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!dseen[k]) begin
          if (stl[k] && (tv[k] !== 1'b1 || td[k] !== pd[k] || tl[k] !== pl[k]))
            hold_err[k]++;
          if (bz[k] !== 1'b1) busy_err[k]++;
          if (dn[k] === 1'b1) begin dseen[k] = 1; done_at[k] = c; end
          if (in_gap[k]) begin
            if (tv[k] === 1'b1) begin
              if (ng[k] < 8) gaps[k][ng[k]] = gcnt[k];
              ng[k]++; in_gap[k] = 0;
            end else gcnt[k]++;
          end
        end
      end
      case (mode)
        0: r = 1'b1;
        1: r = (c % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tready = r;
      start = (c == restart_at);
      for (int k = 0; k < 2; k++) begin
        if (!dseen[k]) begin
          if (tv[k] === 1'b1 && r) begin
            if (nb[k] < 64) begin bd[k][nb[k]] = td[k]; bl[k][nb[k]] = tl[k]; end
            nb[k]++; last_acc[k] = c;
            if (tl[k] === 1'b1) begin in_gap[k] = 1; gcnt[k] = 0; end
          end
          stl[k] = (tv[k] === 1'b1) && !r;
          if (stl[k]) stalls[k]++;
          pd[k] = td[k]; pl[k] = tl[k];
        end
      end
      @(negedge aclk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({tv[k], tl[k], td[k], bz[k], dn[k]} !== 36'h0) begin
        errors++;
        $display("FAIL reset dut%0d got v%b l%b d%h b%b dn%b want all 0",
                 k, tv[k], tl[k], td[k], bz[k], dn[k]);
      end
`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
      checks++;
      if (sc[k] !== 32'h0) begin
        errors++; $display("FAIL reset_stall dut%0d got %h want 0", k, sc[k]);
      end
`endif
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_single;
    tready = 1'b1;
    do_start(32'h0, 16, 1);
    checks++;
    if (tv[0] !== 1'b1 || td[0] !== 32'h0 || bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got v%b d%h b%b want v1 d0 b1", tv[0], td[0], bz[0]);
    end
    collect(0, 60, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (nb[k] !== 16) begin
        errors++; $display("FAIL single_count dut%0d got %0d want 16", k, nb[k]);
      end
      for (int i = 0; i < nb[k] && i < 64; i++) begin
        checks++;
        if (bd[k][i] !== mdata(0, i) || bl[k][i] !== mlast(16, i)) begin
          errors++;
          $display("FAIL single_beat%0d dut%0d got %h/%b want %h/%b",
                   i, k, bd[k][i], bl[k][i], mdata(0, i), mlast(16, i));
        end
      end
      checks++;
      if (done_at[k] !== last_acc[k] + 1 || busy_err[k] != 0) begin
        errors++;
        $display("FAIL single_done dut%0d got done@%0d busyerr %0d want done@%0d busyerr 0",
                 k, done_at[k], busy_err[k], last_acc[k] + 1);
      end
    end
    checks++;
    if (bz[0] !== 1'b0 || dn[0] !== 1'b0) begin
      errors++; $display("FAIL single_idle got b%b dn%b want 0 0", bz[0], dn[0]);
    end
  endtask

  task automatic test_backpressure;
    do_start(32'h100, 4, 1);
    collect(1, 60, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (nb[k] !== 4 || hold_err[k] != 0) begin
        errors++;
        $display("FAIL bp_count dut%0d got n%0d hold %0d want n4 hold 0", k, nb[k], hold_err[k]);
      end
      for (int i = 0; i < nb[k] && i < 64; i++) begin
        checks++;
        if (bd[k][i] !== mdata(32'h100, i) || bl[k][i] !== mlast(4, i)) begin
          errors++;
          $display("FAIL bp_beat%0d dut%0d got %h/%b want %h/%b",
                   i, k, bd[k][i], bl[k][i], mdata(32'h100, i), mlast(4, i));
        end
      end
`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
      checks++;
      if (sc[k] !== 32'(stalls[k])) begin
        errors++; $display("FAIL bp_stall_cnt dut%0d got %0d want %0d", k, sc[k], stalls[k]);
      end
`endif
    end
  endtask

  task automatic test_multi;
    tready = 1'b1;
    do_start(32'h0, 3, 3);
    collect(0, 60, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (nb[k] !== 9 || ng[k] !== 2) begin
        errors++;
        $display("FAIL multi_count dut%0d got n%0d g%0d want n9 g2", k, nb[k], ng[k]);
      end
      for (int i = 0; i < nb[k] && i < 64; i++) begin
        checks++;
        if (bd[k][i] !== mdata(0, i) || bl[k][i] !== mlast(3, i)) begin
          errors++;
          $display("FAIL multi_beat%0d dut%0d got %h/%b want %h/%b",
                   i, k, bd[k][i], bl[k][i], mdata(0, i), mlast(3, i));
        end
      end
      for (int g = 0; g < ng[k] && g < 8; g++) begin
        checks++;
        if (gaps[k][g] !== 2 * k) begin
          errors++; $display("FAIL multi_gap%0d dut%0d got %0d want %0d", g, k, gaps[k][g], 2 * k);
        end
      end
    end
  endtask

  task automatic test_wrap;
    tready = 1'b1;
    do_start(32'hFFFF_FFFE, 4, 1);
    collect(0, 40, -1);
    checks++;
    if (nb[0] !== 4) begin
      errors++; $display("FAIL wrap_count got %0d want 4", nb[0]);
    end
    for (int i = 0; i < nb[0] && i < 64; i++) begin
      checks++;
      if (bd[0][i] !== mdata(32'hFFFF_FFFE, i) || bl[0][i] !== mlast(4, i)) begin
        errors++;
        $display("FAIL wrap_beat%0d got %h/%b want %h/%b",
                 i, bd[0][i], bl[0][i], mdata(32'hFFFF_FFFE, i), mlast(4, i));
      end
    end
  endtask

  task automatic test_degenerate;
    for (int t = 0; t < 2; t++) begin
      do_start(32'h5, (t == 0) ? 0 : 3, (t == 0) ? 2 : 0);
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (tv[k] !== 1'b0 || bz[k] !== 1'b0) begin
            errors++;
            $display("FAIL degenerate%0d dut%0d got v%b b%b want 0 0", t, k, tv[k], bz[k]);
          end
        end
        @(negedge aclk);
      end
    end
  endtask

  task automatic test_restart_ignored;
    tready = 1'b1;
    do_start(32'h50, 5, 2);
    seed = 32'hABC; pkt_len = 16'd1; num_pkts = 8'd7;
    collect(0, 60, 3);
    checks++;
    if (nb[0] !== 10) begin
      errors++; $display("FAIL restart_count got %0d want 10", nb[0]);
    end
    for (int i = 0; i < nb[0] && i < 64; i++) begin
      checks++;
      if (bd[0][i] !== mdata(32'h50, i) || bl[0][i] !== mlast(5, i)) begin
        errors++;
        $display("FAIL restart_beat%0d got %h/%b want %h/%b",
                 i, bd[0][i], bl[0][i], mdata(32'h50, i), mlast(5, i));
      end
    end
    checks++;
    if (bz[0] !== 1'b0 || tv[0] !== 1'b0) begin
      errors++; $display("FAIL restart_idle got b%b v%b want 0 0", bz[0], tv[0]);
    end
  endtask

  task automatic test_random;
    int len, num;
    logic [31:0] s;
    for (int it = 0; it < 6; it++) begin
      s = $urandom;
      len = (it == 0) ? 1 : int'($urandom_range(1, 8));
      num = int'($urandom_range(1, 4));
      do_start(s, len, num);
      collect(2, 400, -1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (nb[k] !== len * num || ng[k] !== num - 1 || hold_err[k] != 0 ||
            done_at[k] !== last_acc[k] + 1) begin
          errors++;
          $display("FAIL rand%0d_run dut%0d got n%0d g%0d hold%0d done@%0d want n%0d g%0d hold0 done@%0d",
                   it, k, nb[k], ng[k], hold_err[k], done_at[k], len * num, num - 1, last_acc[k] + 1);
        end
        for (int i = 0; i < nb[k] && i < 64; i++) begin
          checks++;
          if (bd[k][i] !== mdata(s, i) || bl[k][i] !== mlast(len, i)) begin
            errors++;
            $display("FAIL rand%0d_beat%0d dut%0d got %h/%b want %h/%b",
                     it, i, k, bd[k][i], bl[k][i], mdata(s, i), mlast(len, i));
          end
        end
        for (int g = 0; g < ng[k] && g < 8; g++) begin
          checks++;
          if (gaps[k][g] !== 2 * k) begin
            errors++;
            $display("FAIL rand%0d_gap%0d dut%0d got %0d want %0d", it, g, k, gaps[k][g], 2 * k);
          end
        end
`ifdef AXIS_PACKET_GEN_STALL_CNT_EN
        checks++;
        if (sc[k] !== 32'(stalls[k])) begin
          errors++;
          $display("FAIL rand%0d_stall_cnt dut%0d got %0d want %0d", it, k, sc[k], stalls[k]);
        end
`endif
      end
    end
  endtask

  task automatic test_reset_mid;
    tready = 1'b1;
    do_start(32'h0, 16, 1);
    repeat (5) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tv[k] !== 1'b0 || bz[k] !== 1'b0 || dn[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d got v%b b%b dn%b want 0 0 0", k, tv[k], bz[k], dn[k]);
      end
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    do_start(32'h20, 4, 1);
    collect(0, 40, -1);
    checks++;
    if (nb[0] !== 4) begin
      errors++; $display("FAIL reset_mid_count got %0d want 4", nb[0]);
    end
    for (int i = 0; i < nb[0] && i < 64; i++) begin
      checks++;
      if (bd[0][i] !== mdata(32'h20, i) || bl[0][i] !== mlast(4, i)) begin
        errors++;
        $display("FAIL reset_mid_beat%0d got %h/%b want %h/%b",
                 i, bd[0][i], bl[0][i], mdata(32'h20, i), mlast(4, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_multi();
    test_wrap();
    test_degenerate();
    test_restart_ignored();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packet_gen.md
Name: axis_packet_gen

Overview:
AXI4-Stream master that generates test packets of incrementing data for the downstream AXIS data FIFO slave port. Software or a bench pulses start with a seed, a packet length and a packet count. The block then emits that many tlast-framed packets, with an optional idle gap between packets. It fully honours tready backpressure. Used for bring-up and throughput tests of the FIFO and later stream stages.

Parameters:
DATA_WIDTH, 32, width of m_axis_tdata and of the seed/data counter
LEN_WIDTH, 16, width of pkt_len (beats per packet, max 2^LEN_WIDTH-1)
CNT_WIDTH, 8, width of num_pkts (packets per run)
GAP_CYCLES, 0, idle cycles with tvalid low between consecutive packets of a run; 0 = back-to-back

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle run request, sampled only in IDLE
seed  in  DATA_WIDTH  first data word of the run
pkt_len  in  LEN_WIDTH  beats per packet
num_pkts  in  CNT_WIDTH  packets in the run
busy  out  1  run in progress
done  out  1  one-cycle pulse after the final beat of the run is accepted
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready from the FIFO
m_axis_tlast  out  1  last beat of packet

Behaviour:
- Reset (async assert, sync release): state IDLE; tvalid=0, tlast=0, tdata=0, busy=0, done=0; all counters 0. Asserting reset mid-packet drops tvalid in the same instant. No partial packet is resumed after reset.
- All outputs are registered. There is no combinational path from tready to any output.
- FSM states: IDLE, SEND, GAP, FINISH.
- IDLE:
  - start=1 with pkt_len!=0 and num_pkts!=0 latches seed, pkt_len and num_pkts.
  - Moves to SEND. tvalid=1, tdata=seed and busy=1 are visible on the next edge (1-cycle latency).
  - start with pkt_len==0 or num_pkts==0 is ignored: state stays IDLE, busy stays 0.
- SEND, per beat:
  - A beat is accepted when tvalid && tready on a rising edge.
  - While tvalid=1 and tready=0, tdata and tlast hold stable (AXIS rule).
  - Beat index counts 0..pkt_len-1. tlast=1 exactly on index pkt_len-1; pkt_len=1 means every beat carries tlast.
  - tdata increments by 1 per accepted beat, modulo 2^DATA_WIDTH. It continues across packets of a run and does not reload the seed per packet.
- End of a packet (tlast beat accepted):
  - If this was the last packet of the run: tvalid=0, go to FINISH.
  - Otherwise, if GAP_CYCLES=0: stay in SEND with tvalid held 1. The next packet's first beat is presented on the following cycle with no bubble.
  - Otherwise: go to GAP with tvalid=0 for exactly GAP_CYCLES cycles, then return to SEND.
- FINISH: done=1 for one cycle; busy=0 and return to IDLE on the same edge. A new start is accepted on the cycle after done.
- start while busy=1 is ignored. Input changes to seed, pkt_len and num_pkts during a run have no effect.
- Counter widths: beat counter LEN_WIDTH bits, packet counter CNT_WIDTH bits. Neither counter ever wraps within a run.

Optional Feature:
Macro AXIS_PACKET_GEN_STALL_CNT_EN.
- Defined: adds output port stall_cnt [31:0]. It increments every cycle with tvalid=1 and tready=0, saturates at 0xFFFFFFFF, clears on reset and on each accepted start.
- Not defined: port and logic are absent. Stream behaviour is identical in both builds.

Test Plan:
- Run of 1 packet, seed=0, pkt_len=16, num_pkts=1, tready=1 → 16 consecutive beats with data 0..15. tlast only on data 15. done pulses 1 cycle after the beat with data 15 is accepted. busy is high from the cycle after start until done.
- Backpressure: seed=0x100, pkt_len=4, tready toggling 1,0,0,1,… → accepted sequence 0x100..0x103. Data and tlast stable during every stall. With the macro defined, stall_cnt equals the number of stall cycles.
- Multi-packet run: GAP_CYCLES=0, seed=0, pkt_len=3, num_pkts=3 → 9 beats with data 0..8, tlast on 2, 5 and 8, tvalid never low between packets. Rebuild with GAP_CYCLES=2 → exactly 2 tvalid-low cycles after beats 2 and 5 only.
- Wrap and degenerate inputs: seed=0xFFFFFFFE, pkt_len=4 → data FFFFFFFE, FFFFFFFF, 00000000, 00000001. start with pkt_len=0 → no tvalid, busy stays 0. A second start during a run is ignored.
- Reset mid-packet: deassert aresetn after beat 5 of a 16-beat packet → tvalid, busy and done go to 0 immediately. After release, a new start with seed=0x20 begins cleanly at 0x20 with tlast on the new packet's final beat.
